// File: rtl/instr_enc_pkg.sv
`default_nettype none
// ============================================================================
// Package : instr_enc_pkg
// Brief   : Request kinds, ALU op codes, opcodes and CSR numbers for the encoder
// Revision: 1.0
// ============================================================================
package instr_enc_pkg;

   typedef enum logic [2:0] {
      KIND_R        = 3'd0,
      KIND_I        = 3'd1,
      KIND_LUI      = 3'd2,
      KIND_CSRW_HEX = 3'd3,
      KIND_CSRR_SW  = 3'd4
   } req_kind_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FULL  = 2'd3
   } enc_state_e;

   // ALU op encoding shared with the core's control-field decoder
   localparam logic [3:0] c_alu_and   = 4'b0000;
   localparam logic [3:0] c_alu_or    = 4'b0001;
   localparam logic [3:0] c_alu_xor   = 4'b0010;
   localparam logic [3:0] c_alu_add   = 4'b0011;
   localparam logic [3:0] c_alu_sub   = 4'b0100;
   localparam logic [3:0] c_alu_mul   = 4'b0101;
   localparam logic [3:0] c_alu_mulh  = 4'b0110;
   localparam logic [3:0] c_alu_mulhu = 4'b0111;
   localparam logic [3:0] c_alu_sll   = 4'b1000;
   localparam logic [3:0] c_alu_srl   = 4'b1001;
   localparam logic [3:0] c_alu_sra   = 4'b1010;
   localparam logic [3:0] c_alu_slt   = 4'b1100;
   localparam logic [3:0] c_alu_sltu  = 4'b1101;

   localparam logic [6:0] c_op_r      = 7'h33;
   localparam logic [6:0] c_op_imm    = 7'h13;
   localparam logic [6:0] c_op_lui    = 7'h37;
   localparam logic [6:0] c_op_system = 7'h73;

   localparam logic [6:0] c_f7_base   = 7'h00;
   localparam logic [6:0] c_f7_muldiv = 7'h01;
   localparam logic [6:0] c_f7_alt    = 7'h20;
   localparam logic [2:0] c_f3_csrrw  = 3'b001;

   localparam logic [11:0] c_csr_sw   = 12'hF00;
   localparam logic [11:0] c_csr_hex  = 12'hF02;

endpackage
`default_nettype wire

// File: rtl/instr_word_gen.sv
`default_nettype none
// ============================================================================
// Module  : instr_word_gen
// Brief   : Combinational field-level request to RV32 machine word encoder
// Revision: 1.0
// ============================================================================
module instr_word_gen
   import instr_enc_pkg::*;
(
   input  logic [2:0]  kind,
   input  logic [3:0]  aluop,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [19:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   logic [6:0]  w_f7;
   logic [2:0]  w_f3;
   logic [11:0] w_imm12;

   always_comb begin
      w_f7    = c_f7_base;
      w_f3    = 3'd0;
      w_imm12 = 12'h000;
      word    = 32'h0000_0000;
      illegal = 1'b0;
      case (kind)
         KIND_R: begin
            case (aluop)
               c_alu_add:   w_f3 = 3'd0;
               c_alu_sll:   w_f3 = 3'd1;
               c_alu_slt:   w_f3 = 3'd2;
               c_alu_sltu:  w_f3 = 3'd3;
               c_alu_xor:   w_f3 = 3'd4;
               c_alu_srl:   w_f3 = 3'd5;
               c_alu_or:    w_f3 = 3'd6;
               c_alu_and:   w_f3 = 3'd7;
               c_alu_mul:   begin w_f7 = c_f7_muldiv; w_f3 = 3'd0; end
               c_alu_mulh:  begin w_f7 = c_f7_muldiv; w_f3 = 3'd1; end
               c_alu_mulhu: begin w_f7 = c_f7_muldiv; w_f3 = 3'd3; end
               c_alu_sub:   begin w_f7 = c_f7_alt;    w_f3 = 3'd0; end
               c_alu_sra:   begin w_f7 = c_f7_alt;    w_f3 = 3'd5; end
               default:     illegal = 1'b1;
            endcase
            word = {w_f7, rs2, rs1, w_f3, rd, c_op_r};
         end
         KIND_I: begin
            // shift-immediates carry only a 5-bit shamt; upper bits select srl/sra
            case (aluop)
               c_alu_add: begin w_f3 = 3'd0; w_imm12 = imm[11:0]; end
               c_alu_xor: begin w_f3 = 3'd4; w_imm12 = imm[11:0]; end
               c_alu_or:  begin w_f3 = 3'd6; w_imm12 = imm[11:0]; end
               c_alu_and: begin w_f3 = 3'd7; w_imm12 = imm[11:0]; end
               c_alu_sll: begin w_f3 = 3'd1; w_imm12 = {c_f7_base, imm[4:0]}; end
               c_alu_srl: begin w_f3 = 3'd5; w_imm12 = {c_f7_base, imm[4:0]}; end
               c_alu_sra: begin w_f3 = 3'd5; w_imm12 = {c_f7_alt,  imm[4:0]}; end
               default:   illegal = 1'b1;
            endcase
            word = {w_imm12, rs1, w_f3, rd, c_op_imm};
         end
         KIND_LUI:      word = {imm, rd, c_op_lui};
         KIND_CSRW_HEX: word = {c_csr_hex, rs1, c_f3_csrrw, 5'd0, c_op_system};
         KIND_CSRR_SW:  word = {c_csr_sw, 5'd0, c_f3_csrrw, rd, c_op_system};
         default:       illegal = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module  : instr_encoder
// Brief   : Request-to-RV32 encoder feeding instruction memory via valid/ready
// Revision: 1.0
// ============================================================================
module instr_encoder
   import instr_enc_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          done,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [2:0]    req_kind,
   input  logic [3:0]    req_aluop,
   input  logic [4:0]    req_rd,
   input  logic [4:0]    req_rs1,
   input  logic [4:0]    req_rs2,
   input  logic [19:0]   req_imm,
   output logic          mem_valid,
   input  logic          mem_ready,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          busy,
   output logic          full,
   output logic          err,
   output logic [7:0]    err_count
);

   localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);

   enc_state_e    r_state;
   logic          r_mem_valid;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_wdata;
   logic          r_err;
   logic [7:0]    r_err_count;

   logic [31:0]   w_word;
   logic          w_illegal;
   logic          w_req_fire;
   logic          w_mem_fire;
   logic          w_last_fire;

   instr_word_gen u_word_gen (
      .kind    (req_kind),
      .aluop   (req_aluop),
      .rd      (req_rd),
      .rs1     (req_rs1),
      .rs2     (req_rs2),
      .imm     (req_imm),
      .word    (w_word),
      .illegal (w_illegal)
   );

   assign req_ready   = (r_state == ST_LOAD) && (!r_mem_valid || mem_ready);
   assign w_req_fire  = req_valid && req_ready;
   assign w_mem_fire  = r_mem_valid && mem_ready;
   assign w_last_fire = w_mem_fire && (r_addr == c_last_addr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_mem_valid <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= 32'h0000_0000;
         r_err       <= 1'b0;
         r_err_count <= 8'd0;
      end else if (start) begin
         r_state     <= ST_LOAD;
         r_mem_valid <= 1'b0;
         r_addr      <= '0;
         r_err       <= 1'b0;
         r_err_count <= 8'd0;
      end else begin
         if (w_mem_fire) begin
            r_addr <= r_addr + AW'(1);
         end
         if (w_req_fire && w_illegal) begin
            r_err <= 1'b1;
            if (r_err_count != 8'hFF) begin
               r_err_count <= r_err_count + 8'd1;
            end
         end
         case (r_state)
            ST_LOAD: begin
               // memory is full: anything accepted alongside the last word has nowhere to go
               if (w_last_fire) begin
                  r_state     <= ST_FULL;
                  r_mem_valid <= 1'b0;
               end else begin
                  if (w_req_fire && !w_illegal) begin
                     r_mem_valid <= 1'b1;
                     r_wdata     <= w_word;
                  end else if (w_mem_fire) begin
                     r_mem_valid <= 1'b0;
                  end
                  if (done) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_mem_fire) begin
                  r_mem_valid <= 1'b0;
               end
               if (!r_mem_valid || w_mem_fire) begin
                  r_state <= ST_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_valid = r_mem_valid;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign busy      = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
   assign full      = (r_state == ST_FULL);
   assign err       = r_err;
   assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_encoder
// Brief   : Randomized bench for instr_encoder against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_instr_encoder;

   localparam int DEPTH   = 4;
   localparam int AW      = 2;
   localparam int M_IDLE  = 0;
   localparam int M_LOAD  = 1;
   localparam int M_DRAIN = 2;
   localparam int M_FULL  = 3;

   logic          clk = 1'b0;
   logic          rst_n, start, done, req_valid, req_ready;
   logic [2:0]    req_kind;
   logic [3:0]    req_aluop;
   logic [4:0]    req_rd, req_rs1, req_rs2;
   logic [19:0]   req_imm;
   logic          mem_valid, mem_ready;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          busy, full, err;
   logic [7:0]    err_count;

   instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .done(done),
      .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
      .req_aluop(req_aluop), .req_rd(req_rd), .req_rs1(req_rs1),
      .req_rs2(req_rs2), .req_imm(req_imm), .mem_valid(mem_valid),
      .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .full(full), .err(err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // model: mode, words accepted but not yet written, words written since start
   int          m_mode;
   logic [31:0] m_q[$];
   int          m_wr;
   bit          m_err;
   int          m_cnt;

   typedef struct packed {logic ok; logic [6:0] f7; logic [2:0] f3;} rdef_t;
   typedef struct packed {logic ok; logic shift; logic [6:0] hi; logic [2:0] f3;} idef_t;
   rdef_t rtab [16];
   idef_t itab [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fill_tables();
      for (int i = 0; i < 16; i++) begin
         rtab[i] = '0;
         itab[i] = '0;
      end
      rtab[4'b0011] = {1'b1, 7'h00, 3'd0};
      rtab[4'b1000] = {1'b1, 7'h00, 3'd1};
      rtab[4'b1100] = {1'b1, 7'h00, 3'd2};
      rtab[4'b1101] = {1'b1, 7'h00, 3'd3};
      rtab[4'b0010] = {1'b1, 7'h00, 3'd4};
      rtab[4'b1001] = {1'b1, 7'h00, 3'd5};
      rtab[4'b0001] = {1'b1, 7'h00, 3'd6};
      rtab[4'b0000] = {1'b1, 7'h00, 3'd7};
      rtab[4'b0101] = {1'b1, 7'h01, 3'd0};
      rtab[4'b0110] = {1'b1, 7'h01, 3'd1};
      rtab[4'b0111] = {1'b1, 7'h01, 3'd3};
      rtab[4'b0100] = {1'b1, 7'h20, 3'd0};
      rtab[4'b1010] = {1'b1, 7'h20, 3'd5};
      itab[4'b0011] = {1'b1, 1'b0, 7'h00, 3'd0};
      itab[4'b0010] = {1'b1, 1'b0, 7'h00, 3'd4};
      itab[4'b0001] = {1'b1, 1'b0, 7'h00, 3'd6};
      itab[4'b0000] = {1'b1, 1'b0, 7'h00, 3'd7};
      itab[4'b1000] = {1'b1, 1'b1, 7'h00, 3'd1};
      itab[4'b1001] = {1'b1, 1'b1, 7'h00, 3'd5};
      itab[4'b1010] = {1'b1, 1'b1, 7'h20, 3'd5};
   endtask

   function automatic bit encode(input int k, input int a, input int rd, input int rs1,
                                 input int rs2, input int imm, output logic [31:0] w);
      int imm12;
      w = 32'h0;
      case (k)
         0: begin
            w = (int'(rtab[a].f7) << 25) | (rs2 << 20) | (rs1 << 15) | (int'(rtab[a].f3) << 12) | (rd << 7) | 'h33;
            return rtab[a].ok;
         end
         1: begin
            imm12 = itab[a].shift ? (int'(itab[a].hi) * 32 + imm % 32) : imm % 4096;
            w = (imm12 << 20) | (rs1 << 15) | (int'(itab[a].f3) << 12) | (rd << 7) | 'h13;
            return itab[a].ok;
         end
         2: begin w = imm * 4096 + rd * 128 + 'h37; return 1'b1; end
         3: begin w = ('hF02 << 20) | (rs1 << 15) | (1 << 12) | 'h73; return 1'b1; end
         4: begin w = ('hF00 << 20) | (1 << 12) | (rd << 7) | 'h73; return 1'b1; end
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit exp_rr();
      return (m_mode == M_LOAD) && (m_q.size() == 0 || mem_ready);
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE;
      m_q.delete();
      m_wr   = 0;
      m_err  = 1'b0;
      m_cnt  = 0;
   endtask

   task automatic model_step();
      bit acc, fire;
      logic [31:0] w;
      if (!rst_n) begin
         model_reset();
         return;
      end
      acc  = req_valid && exp_rr();
      fire = (m_q.size() != 0) && mem_ready;
      if (start) begin
         model_reset();
         m_mode = M_LOAD;
         return;
      end
      if (fire) begin
         void'(m_q.pop_front());
         m_wr++;
      end
      if (acc) begin
         if (encode(req_kind, req_aluop, req_rd, req_rs1, req_rs2, req_imm, w)) begin
            m_q.push_back(w);
         end else begin
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
         end
      end
      if (m_mode == M_LOAD && fire && m_wr == DEPTH) begin
         m_mode = M_FULL;
         m_q.delete();
      end else if (m_mode == M_LOAD && done) begin
         m_mode = M_DRAIN;
      end else if (m_mode == M_DRAIN && m_q.size() == 0) begin
         m_mode = M_IDLE;
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("req_ready", 32'(req_ready), 32'(exp_rr()));
         check("mem_valid", 32'(mem_valid), 32'(m_q.size() != 0));
         if (m_q.size() != 0) check("mem_wdata", mem_wdata, m_q[0]);
         check("mem_addr", 32'(mem_addr), 32'(m_wr % DEPTH));
         check("busy", 32'(busy), 32'(m_mode == M_LOAD || m_mode == M_DRAIN));
         check("full", 32'(full), 32'(m_mode == M_FULL));
         check("err", 32'(err), 32'(m_err));
         check("err_count", 32'(err_count), 32'(m_cnt));
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input logic [2:0] k, input logic [3:0] a, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [19:0] im);
      req_valid = 1'b1; req_kind = k; req_aluop = a;
      req_rd = d; req_rs1 = s1; req_rs2 = s2; req_imm = im;
   endtask

   task automatic do_start();
      start = 1'b1; done = 1'b0; req_valid = 1'b0;
      tick();
      start = 1'b0;
   endtask

   initial begin
      fill_tables();
      rst_n = 1'b0; start = 1'b0; done = 1'b0; mem_ready = 1'b0;
      req_valid = 1'b0; req_kind = '0; req_aluop = '0;
      req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
      model_reset();
      chk_en = 1'b1;
      repeat (2) tick();
      check("reset wdata", mem_wdata, 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      tick();

      // R add, one-cycle latency
      do_start();
      mem_ready = 1'b1;
      drive(3'd0, 4'b0011, 5'd3, 5'd1, 5'd2, 20'h0);
      tick();
      req_valid = 1'b0;
      check("add valid", 32'(mem_valid), 32'h1);
      check("add addr", 32'(mem_addr), 32'h0);
      check("add word", mem_wdata, 32'h002081B3);
      check("model add", m_q[0], 32'h002081B3);
      tick();

      // I srai held under back-pressure
      do_start();
      mem_ready = 1'b0;
      drive(3'd1, 4'b1010, 5'd5, 5'd6, 5'd0, 20'h3);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("srai word", mem_wdata, 32'h40335293);
         check("srai stall ready", 32'(req_ready), 32'h0);
         check("srai addr", 32'(mem_addr), 32'h0);
         tick();
      end
      mem_ready = 1'b1;
      #1;
      check("srai ready", 32'(req_ready), 32'h1);
      tick();
      check("srai done valid", 32'(mem_valid), 32'h0);
      check("srai next addr", 32'(mem_addr), 32'h1);

      // back-to-back LUI / CSRW_HEX / CSRR_SW
      do_start();
      drive(3'd2, 4'd0, 5'd7, 5'd0, 5'd0, 20'h12345);
      tick();
      check("lui word", mem_wdata, 32'h123453B7);
      check("lui addr", 32'(mem_addr), 32'h0);
      drive(3'd3, 4'd0, 5'd0, 5'd9, 5'd0, 20'h0);
      tick();
      check("csrw word", mem_wdata, 32'hF0249073);
      check("csrw addr", 32'(mem_addr), 32'h1);
      drive(3'd4, 4'd0, 5'd4, 5'd0, 5'd0, 20'h0);
      tick();
      check("csrr word", mem_wdata, 32'hF0001273);
      check("csrr addr", 32'(mem_addr), 32'h2);
      req_valid = 1'b0;
      tick();

      // illegal requests
      do_start();
      drive(3'd0, 4'b1111, 5'd1, 5'd2, 5'd3, 20'h0);
      tick();
      drive(3'd1, 4'b1100, 5'd1, 5'd2, 5'd3, 20'h5);
      tick();
      req_valid = 1'b0;
      check("ill valid", 32'(mem_valid), 32'h0);
      check("ill err", 32'(err), 32'h1);
      check("ill count", 32'(err_count), 32'h2);
      check("ill addr", 32'(mem_addr), 32'h0);
      drive(3'd0, 4'b0011, 5'd3, 5'd1, 5'd2, 20'h0);
      tick();
      req_valid = 1'b0;
      check("post-ill valid", 32'(mem_valid), 32'h1);
      check("post-ill addr", 32'(mem_addr), 32'h0);
      tick();

      // fill to DEPTH
      do_start();
      drive(3'd5, 4'd0, 5'd0, 5'd0, 5'd0, 20'h0);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(3'd0, 4'b0011, 5'(i + 1), 5'd1, 5'd2, 20'h0);
         tick();
      end
      req_valid = 1'b0;
      tick();
      check("full flag", 32'(full), 32'h1);
      check("full ready", 32'(req_ready), 32'h0);
      check("full valid", 32'(mem_valid), 32'h0);
      check("full err", 32'(err), 32'h1);
      do_start();
      check("restart busy", 32'(busy), 32'h1);
      check("restart full", 32'(full), 32'h0);
      check("restart addr", 32'(mem_addr), 32'h0);
      check("restart err", 32'(err), 32'h0);

      // done while a word is stalled
      mem_ready = 1'b0;
      drive(3'd0, 4'b0100, 5'd8, 5'd9, 5'd10, 20'h0);
      tick();
      req_valid = 1'b0;
      done = 1'b1;
      tick();
      done = 1'b0;
      check("drain busy", 32'(busy), 32'h1);
      check("drain valid", 32'(mem_valid), 32'h1);
      repeat (2) tick();
      check("drain hold", 32'(busy), 32'h1);
      mem_ready = 1'b1;
      tick();
      check("drain idle", 32'(busy), 32'h0);
      check("drain addr", 32'(mem_addr), 32'h1);

      // async reset mid-stall
      do_start();
      mem_ready = 1'b0;
      drive(3'd2, 4'd0, 5'd1, 5'd0, 5'd0, 20'hABCDE);
      tick();
      req_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("rst valid", 32'(mem_valid), 32'h0);
      check("rst busy", 32'(busy), 32'h0);
      model_reset();
      tick();
      rst_n = 1'b1;
      tick();

      // err_count saturation
      do_start();
      mem_ready = 1'b1;
      drive(3'd7, 4'd0, 5'd0, 5'd0, 5'd0, 20'h0);
      repeat (260) tick();
      req_valid = 1'b0;
      check("err sat", 32'(err_count), 32'hFF);

      // randomized traffic
      repeat (4000) begin
         start     = ($urandom_range(0, 39) == 0);
         done      = ($urandom_range(0, 29) == 0);
         req_valid = ($urandom_range(0, 2) != 0);
         mem_ready = ($urandom_range(0, 3) != 0);
         req_kind  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
         req_aluop = 4'($urandom_range(0, 15));
         req_rd    = 5'($urandom);
         req_rs1   = 5'($urandom);
         req_rs2   = 5'($urandom);
         req_imm   = 20'($urandom);
         tick();
      end
      start = 1'b0; done = 1'b0; req_valid = 1'b0; mem_ready = 1'b1;
      repeat (4) tick();

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
